// File: rtl/tape_stream.sv
// rtl/tape_stream.sv - cassette playback: SDRAM byte prefetch FIFO feeding a bit-cell serializer
// Optional feature macro TAPE_LOOP_EN: wrap to the tape start at end of tape instead of stopping.
module tape_stream #(
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int CELL_DIV   = 1000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] tape_len,
  input  logic              play_toggle,
  input  logic              rewind,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              data,
  output logic              playing,
  output logic              underrun,
  output logic              eot,
  output logic [ADDR_W-1:0] position
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CELL_W = $clog2(CELL_DIV);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fstate_t;

  fstate_t           fstate_q, fstate_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, rd_addr_q, rd_addr_d, len_q, len_d;
  logic              load_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        sh_q, sh_d;
  logic [3:0]        bits_q, bits_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  logic              data_q, data_d, playing_q, playing_d, eot_q, eot_d, starved_q, starved_d;
  logic [ADDR_W-1:0] position_q, position_d, fetch_next, position_next;
  logic              load_fall, flush, fifo_empty, last_cell, push, pop;
  logic [7:0]        fifo_dout;

  assign load_fall  = load_q & ~load;
  assign flush      = rewind | load_fall;
  assign fifo_empty = (count_q == '0);
  assign last_cell  = (cell_q == CELL_W'(CELL_DIV - 1));
  assign fifo_dout  = mem_q[rd_ptr_q];
  // Starved stays set until the pop so a freshly pushed byte does not hide the stall.
  assign underrun   = playing_q && (bits_q == 4'd0) && (position_q < len_q) && (fifo_empty || starved_q);

  assign rd_req   = (fstate_q == F_REQ);
  assign rd_addr  = rd_addr_q;
  assign data     = data_q;
  assign playing  = playing_q;
  assign eot      = eot_q;
  assign position = position_q;

  always_comb begin
    fstate_d     = fstate_q;
    discard_d    = discard_q;
    fetch_addr_d = fetch_addr_q;
    rd_addr_d    = rd_addr_q;
    len_d        = load_fall ? tape_len : len_q;
    push         = 1'b0;
    fetch_next   = fetch_addr_q + ADDR_W'(1);
`ifdef TAPE_LOOP_EN
    if (fetch_next == len_q) fetch_next = '0;
`endif
    case (fstate_q)
      F_IDLE: if (!flush && !load && (fetch_addr_q < len_q) && (count_q < CNT_W'(FIFO_DEPTH))) begin
        fstate_d  = F_REQ;
        rd_addr_d = fetch_addr_q;
      end
      F_REQ: begin
        fstate_d = F_WAIT;
        if (flush) discard_d = 1'b1;
      end
      F_WAIT: begin
        if (rd_valid) begin
          fstate_d  = F_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !flush) begin
            push         = 1'b1;
            fetch_addr_d = fetch_next;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: fstate_d = F_IDLE;
    endcase
    if (flush) fetch_addr_d = '0;
  end

  always_comb begin
    sh_d          = sh_q;
    bits_d        = bits_q;
    cell_d        = cell_q;
    data_d        = data_q;
    playing_d     = playing_q;
    position_d    = position_q;
    starved_d     = starved_q;
    pop           = 1'b0;
    position_next = position_q + ADDR_W'(1);
`ifdef TAPE_LOOP_EN
    if (position_next == len_q) position_next = '0;
    eot_d = eot_q && (len_q == '0);
`else
    eot_d = eot_q;
`endif
    if (flush) begin
      sh_d       = '0;
      bits_d     = '0;
      cell_d     = '0;
      data_d     = 1'b0;
      playing_d  = 1'b0;
      position_d = '0;
      starved_d  = 1'b0;
      eot_d      = load_fall && (tape_len == '0);
    end else begin
      if (play_toggle && !eot_q && (len_q != '0)) playing_d = !playing_q;
      if (load) playing_d = 1'b0;
      if (playing_q && !load) begin
        if (bits_q == 4'd0) begin
          pop = !fifo_empty;
        end else if (!last_cell) begin
          cell_d = cell_q + CELL_W'(1);
        end else begin
          cell_d = '0;
          if (bits_q != 4'd1) begin
            data_d = sh_q[7];
            sh_d   = {sh_q[6:0], 1'b0};
            bits_d = bits_q - 4'd1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            bits_d    = '0;
            starved_d = 1'b1;
`ifndef TAPE_LOOP_EN
            if (position_q == len_q) begin
              eot_d     = 1'b1;
              playing_d = 1'b0;
              data_d    = 1'b0;
              starved_d = 1'b0;
            end
`endif
          end
        end
        if (underrun) starved_d = 1'b1;
        if (pop) begin
          data_d     = fifo_dout[7];
          sh_d       = {fifo_dout[6:0], 1'b0};
          bits_d     = 4'd8;
          cell_d     = '0;
          position_d = position_next;
          starved_d  = 1'b0;
`ifdef TAPE_LOOP_EN
          if (position_next == '0) eot_d = 1'b1;
`endif
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fstate_q     <= F_IDLE;
      discard_q    <= 1'b0;
      fetch_addr_q <= '0;
      rd_addr_q    <= '0;
      len_q        <= '0;
      load_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sh_q         <= '0;
      bits_q       <= '0;
      cell_q       <= '0;
      data_q       <= 1'b0;
      playing_q    <= 1'b0;
      eot_q        <= 1'b0;
      starved_q    <= 1'b0;
      position_q   <= '0;
    end else begin
      fstate_q     <= fstate_d;
      discard_q    <= discard_d;
      fetch_addr_q <= fetch_addr_d;
      rd_addr_q    <= rd_addr_d;
      len_q        <= len_d;
      load_q       <= load;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sh_q         <= sh_d;
      bits_q       <= bits_d;
      cell_q       <= cell_d;
      data_q       <= data_d;
      playing_q    <= playing_d;
      eot_q        <= eot_d;
      starved_q    <= starved_d;
      position_q   <= position_d;
    end
  end
endmodule
